// File: rtl/scan_mux_pkg.sv
// Shared definitions for the scan_mux block: mode encodings and a
// constant clog2 used to size the select/channel fields.
package scan_mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Ceiling log2 for elaboration-time sizing (value >= 2 in this block).
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/scan_mux_ptr.sv
// Round-robin scan pointer with a per-channel dwell counter. Manual mode
// parks the pointer at channel 0 so the next scan starts from the bottom.
// 'last' flags the final dwell sample of the top channel.
module scan_mux_ptr
  import scan_mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int DWELL = 1,
  parameter int SELW  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            mode,
  output logic [SELW-1:0] ptr,
  output logic            last
);

  localparam logic [SELW-1:0] PTR_TOP = SELW'(N - 1);
  localparam logic [7:0]      CNT_TOP = 8'(DWELL - 1);

  logic [SELW-1:0] ptr_r;
  logic [7:0]      cnt_r;
  logic            dwell_done_s;

  assign dwell_done_s = (cnt_r == CNT_TOP);

  // Advance the dwell counter and pointer on enabled scan edges; clear in manual.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= {SELW{1'b0}};
      cnt_r <= 8'd0;
    end else if (en) begin
      if (mode == MODE_MANUAL) begin
        ptr_r <= {SELW{1'b0}};
        cnt_r <= 8'd0;
      end else if (dwell_done_s) begin
        cnt_r <= 8'd0;
        ptr_r <= (ptr_r == PTR_TOP) ? {SELW{1'b0}} : ptr_r + SELW'(1'b1);
      end else begin
        cnt_r <= cnt_r + 8'd1;
      end
    end else begin
      ptr_r <= ptr_r;
      cnt_r <= cnt_r;
    end
  end

  assign ptr  = ptr_r;
  assign last = (ptr_r == PTR_TOP) && dwell_done_s;

endmodule

// File: rtl/scan_mux.sv
// N-to-1 multiplexer with registered output. Manual mode uses a saturating
// select; scan mode walks the channels round-robin via scan_mux_ptr. Every
// output is a flop, so there is no combinational path from i/sel to q.
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int W     = 1,
  parameter  int DWELL = 1,
  localparam int SELW  = clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic [N*W-1:0]  i,
  output logic [W-1:0]    q,
  output logic            q_valid,
  output logic [SELW-1:0] ch,
  output logic            wrap
);

  localparam logic [SELW-1:0] CH_TOP = SELW'(N - 1);

  logic [W-1:0]    chan_s [N];
  logic [SELW-1:0] ptr_s;
  logic            last_s;
  logic [SELW-1:0] eff_s;
  logic [SELW-1:0] idx_s;

  logic [W-1:0]    q_r;
  logic            q_valid_r;
  logic [SELW-1:0] ch_r;
  logic            wrap_r;

  // Unpack the flat input bus into one entry per channel.
  for (genvar k = 0; k < N; k++) begin : g_chan
    assign chan_s[k] = i[k*W +: W];
  end

  scan_mux_ptr #(
    .N     (N),
    .DWELL (DWELL),
    .SELW  (SELW)
  ) u_ptr (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .mode (mode),
    .ptr  (ptr_s),
    .last (last_s)
  );

  // Saturate the manual select and choose between manual and scan index.
  always_comb begin
    eff_s = sel;
    idx_s = ptr_s;
    if (sel > CH_TOP) begin
      eff_s = CH_TOP;
    end else begin
      eff_s = sel;
    end
    if (mode == MODE_SCAN) begin
      idx_s = ptr_s;
    end else begin
      idx_s = eff_s;
    end
  end

  // Load data/channel on enabled edges; valid and wrap are single-cycle flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r       <= {W{1'b0}};
      ch_r      <= {SELW{1'b0}};
      q_valid_r <= 1'b0;
      wrap_r    <= 1'b0;
    end else if (en) begin
      q_r       <= chan_s[idx_s];
      ch_r      <= idx_s;
      q_valid_r <= 1'b1;
      wrap_r    <= (mode == MODE_SCAN) && last_s;
    end else begin
      q_r       <= q_r;
      ch_r      <= ch_r;
      q_valid_r <= 1'b0;
      wrap_r    <= 1'b0;
    end
  end

  assign q       = q_r;
  assign ch      = ch_r;
  assign q_valid = q_valid_r;
  assign wrap    = wrap_r;

endmodule

// File: tb/tb_scan_mux.sv
// Self-checking bench for scan_mux: directed scenarios on an N=4/DWELL=2
// instance and an N=3/DWELL=1 instance, then randomized traffic against a
// position-in-period reference model.
module tb_scan_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        mode;
  logic [1:0]  sel;
  logic [31:0] i4;
  logic [23:0] i3;

  logic [7:0]  q4, q3;
  logic        v4, v3, w4, w3;
  logic [1:0]  ch4, ch3;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state: position within the scan period plus expected outputs
  int          s4, s3;
  logic [7:0]  e_q4, e_q3;
  logic [1:0]  e_ch4, e_ch3;
  logic        e_v4, e_v3, e_w4, e_w3;

  always #5 clk = ~clk;

  scan_mux #(.N(4), .W(8), .DWELL(2)) dut4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .i(i4),
    .q(q4), .q_valid(v4), .ch(ch4), .wrap(w4)
  );

  scan_mux #(.N(3), .W(8), .DWELL(1)) dut3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .i(i3),
    .q(q3), .q_valid(v3), .ch(ch3), .wrap(w3)
  );

  task automatic model_reset();
    s4 = 0; s3 = 0;
    e_q4 = 8'h00; e_q3 = 8'h00; e_ch4 = 2'd0; e_ch3 = 2'd0;
    e_v4 = 1'b0; e_v3 = 1'b0; e_w4 = 1'b0; e_w3 = 1'b0;
  endtask

  // One enabled/disabled edge for a mux with n channels and given dwell.
  task automatic model_one(input int n, input int dwell, input logic [31:0] iv,
                           inout int st, inout logic [7:0] eq, inout logic [1:0] ech,
                           inout logic ev, inout logic ew);
    int c;
    if (en) begin
      if (mode == 1'b0) begin
        c  = (int'(sel) < n) ? int'(sel) : n - 1;
        st = 0;
        ew = 1'b0;
      end else begin
        c  = st / dwell;
        ew = (st == n * dwell - 1);
        st = (st + 1) % (n * dwell);
      end
      eq  = iv[c*8 +: 8];
      ech = 2'(c);
      ev  = 1'b1;
    end else begin
      ev = 1'b0;
      ew = 1'b0;
    end
  endtask

  task automatic model_edge();
    model_one(4, 2, i4, s4, e_q4, e_ch4, e_v4, e_w4);
    model_one(3, 1, {8'h00, i3}, s3, e_q3, e_ch3, e_v3, e_w3);
  endtask

  task automatic tick(input logic e, input logic m, input logic [1:0] s);
    en = e; mode = m; sel = s;
    @(posedge clk);
    if (rst == 1'b0) model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mode = 1'b0; sel = 2'd0;
    i4 = 32'hD3C2B1A0; i3 = 24'h5A4B3C;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    tick(1'b1, 1'b0, 2'd3);
    n_checks++;
    if (q4 !== 8'hD3) begin n_fail++; $display("FAIL reset_pre_q: got %h expected d3", q4); end
    // assert reset away from any edge; outputs must clear at once
    #2; rst = 1'b1; model_reset(); #1;
    n_checks++;
    if ({q4, ch4, v4, w4} !== 12'h000) begin
      n_fail++; $display("FAIL reset_async: got q=%h ch=%0d v=%b w=%b expected all 0", q4, ch4, v4, w4);
    end
    @(negedge clk); rst = 1'b0;
    for (int t = 0; t < 2; t++) begin
      tick(1'b0, 1'b0, 2'd0);
      n_checks++;
      if (v4 !== 1'b0 || q4 !== 8'h00) begin
        n_fail++; $display("FAIL reset_idle: got v=%b q=%h expected v=0 q=00", v4, q4);
      end
    end
  endtask

  task automatic test_manual();
    tick(1'b1, 1'b0, 2'd2);
    n_checks++;
    if (q4 !== 8'hC2 || ch4 !== 2'd2 || v4 !== 1'b1 || w4 !== 1'b0) begin
      n_fail++; $display("FAIL manual_sel2: got q=%h ch=%0d v=%b w=%b expected c2 2 1 0", q4, ch4, v4, w4);
    end
    tick(1'b1, 1'b0, 2'd1);
    n_checks++;
    if (q4 !== 8'hB1 || ch4 !== 2'd1) begin
      n_fail++; $display("FAIL manual_sel1: got q=%h ch=%0d expected b1 1", q4, ch4);
    end
  endtask

  task automatic test_scan_sequence();
    logic [7:0] xq [9] = '{8'hA0, 8'hA0, 8'hB1, 8'hB1, 8'hC2, 8'hC2, 8'hD3, 8'hD3, 8'hA0};
    logic [1:0] xc [9] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
    for (int t = 0; t < 9; t++) begin
      tick(1'b1, 1'b1, 2'd2);
      n_checks++;
      if (q4 !== xq[t] || ch4 !== xc[t] || v4 !== 1'b1 || w4 !== (t == 7)) begin
        n_fail++;
        $display("FAIL scan_seq[%0d]: got q=%h ch=%0d v=%b w=%b expected q=%h ch=%0d v=1 w=%b",
                 t, q4, ch4, v4, w4, xq[t], xc[t], (t == 7));
      end
    end
  endtask

  task automatic test_pause();
    tick(1'b1, 1'b0, 2'd0);
    repeat (3) tick(1'b1, 1'b1, 2'd0);
    n_checks++;
    if (q4 !== 8'hB1) begin n_fail++; $display("FAIL pause_pre: got %h expected b1", q4); end
    for (int t = 0; t < 3; t++) begin
      tick(1'b0, 1'b1, 2'd0);
      n_checks++;
      if (v4 !== 1'b0 || q4 !== 8'hB1 || w4 !== 1'b0) begin
        n_fail++; $display("FAIL pause_gap[%0d]: got v=%b q=%h expected v=0 q=b1", t, v4, q4);
      end
    end
    tick(1'b1, 1'b1, 2'd0);
    n_checks++;
    if (q4 !== 8'hB1 || v4 !== 1'b1) begin
      n_fail++; $display("FAIL pause_resume0: got q=%h v=%b expected b1 1", q4, v4);
    end
    tick(1'b1, 1'b1, 2'd0);
    n_checks++;
    if (q4 !== 8'hC2 || ch4 !== 2'd2) begin
      n_fail++; $display("FAIL pause_resume1: got q=%h ch=%0d expected c2 2", q4, ch4);
    end
  endtask

  task automatic test_mode_switch();
    tick(1'b1, 1'b0, 2'd0);
    repeat (5) tick(1'b1, 1'b1, 2'd0);
    tick(1'b1, 1'b0, 2'd3);
    n_checks++;
    if (q4 !== 8'hD3 || ch4 !== 2'd3 || w4 !== 1'b0) begin
      n_fail++; $display("FAIL switch_manual: got q=%h ch=%0d w=%b expected d3 3 0", q4, ch4, w4);
    end
    tick(1'b1, 1'b1, 2'd3);
    n_checks++;
    if (q4 !== 8'hA0 || ch4 !== 2'd0) begin
      n_fail++; $display("FAIL switch_rescan: got q=%h ch=%0d expected a0 0", q4, ch4);
    end
    repeat (4) tick(1'b1, 1'b1, 2'd0);
    n_checks++;
    if (q4 !== 8'hC2) begin n_fail++; $display("FAIL switch_at_ch2: got %h expected c2", q4); end
    #2; rst = 1'b1; model_reset();
    @(negedge clk); rst = 1'b0;
    tick(1'b1, 1'b1, 2'd0);
    n_checks++;
    if (q4 !== 8'hA0 || ch4 !== 2'd0 || v4 !== 1'b1) begin
      n_fail++; $display("FAIL switch_after_rst: got q=%h ch=%0d v=%b expected a0 0 1", q4, ch4, v4);
    end
  endtask

  task automatic test_odd_n();
    logic [1:0] xc [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    logic [7:0] xq [4] = '{8'h3C, 8'h4B, 8'h5A, 8'h3C};
    tick(1'b1, 1'b0, 2'd3);
    n_checks++;
    if (ch3 !== 2'd2 || q3 !== 8'h5A) begin
      n_fail++; $display("FAIL odd_saturate: got ch=%0d q=%h expected 2 5a", ch3, q3);
    end
    for (int t = 0; t < 4; t++) begin
      tick(1'b1, 1'b1, 2'd0);
      n_checks++;
      if (ch3 !== xc[t] || q3 !== xq[t] || w3 !== (t == 2)) begin
        n_fail++;
        $display("FAIL odd_scan[%0d]: got ch=%0d q=%h w=%b expected ch=%0d q=%h w=%b",
                 t, ch3, q3, w3, xc[t], xq[t], (t == 2));
      end
    end
  endtask

  task automatic test_random();
    int wraps4;
    wraps4 = 0;
    for (int t = 0; t < 400; t++) begin
      i4 = $urandom;
      i3 = 24'($urandom);
      if ($urandom_range(0, 99) < 2) begin
        #2; rst = 1'b1; model_reset();
        @(negedge clk); rst = 1'b0;
      end
      tick(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) != 0), 2'($urandom));
      if (w4 === 1'b1) wraps4++;
      n_checks++;
      if (q4 !== e_q4 || ch4 !== e_ch4) begin
        n_fail++; $display("FAIL rand4_data[%0d]: got q=%h ch=%0d expected q=%h ch=%0d", t, q4, ch4, e_q4, e_ch4);
      end
      n_checks++;
      if (v4 !== e_v4 || w4 !== e_w4) begin
        n_fail++; $display("FAIL rand4_flags[%0d]: got v=%b w=%b expected v=%b w=%b", t, v4, w4, e_v4, e_w4);
      end
      n_checks++;
      if (q3 !== e_q3 || ch3 !== e_ch3) begin
        n_fail++; $display("FAIL rand3_data[%0d]: got q=%h ch=%0d expected q=%h ch=%0d", t, q3, ch3, e_q3, e_ch3);
      end
      n_checks++;
      if (v3 !== e_v3 || w3 !== e_w3) begin
        n_fail++; $display("FAIL rand3_flags[%0d]: got v=%b w=%b expected v=%b w=%b", t, v3, w3, e_v3, e_w3);
      end
    end
    n_checks++;
    if (wraps4 == 0) begin
      n_fail++; $display("FAIL rand_wrap_seen: got %0d wrap pulses expected at least 1", wraps4);
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_scan_sequence();
    test_pause();
    test_mode_switch();
    test_odd_n();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
